// File: rtl/vic_wb.sv
// Vectored interrupt controller for the MC1201.02 board: level requests in, virq/istb/ivec/iack handshake out.
// Optional define VIC_ROUND_ROBIN_EN replaces fixed priority (channel 0 highest) with a rotating search start.
module vic_wb #(
    parameter int          NUM_IRQ  = 8,
    parameter logic [15:0] VEC_NONE = 16'o000000
) (
    input  logic                    clk_p,
    input  logic                    rst_n,
    input  logic                    vm_init,
    input  logic [NUM_IRQ-1:0]      irq_req,
    input  logic [16*NUM_IRQ-1:0]   irq_vec,
    output logic [NUM_IRQ-1:0]      irq_ack,
    output logic                    virq,
    input  logic                    istb,
    output logic [15:0]             ivec,
    output logic                    iack
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, SEL, ACK, HOLD} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               sel_vld_q, sel_vld_d;
    logic [15:0]        ivec_q, ivec_d;
    logic [1:0]         guard_q, guard_d;
    logic               virq_q, virq_d;
    logic               win_vld;
    int                 win_ch;
`ifdef VIC_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   rr_q, rr_d;
`endif

    // Winner search: iterate from the far end so the first channel in search order is assigned last.
    always_comb begin
        win_vld = 1'b0;
        win_ch  = 0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
`ifdef VIC_ROUND_ROBIN_EN
            if (irq_req[(int'(rr_q) + k) % NUM_IRQ]) begin
                win_vld = 1'b1;
                win_ch  = (int'(rr_q) + k) % NUM_IRQ;
            end
`else
            if (irq_req[k]) begin
                win_vld = 1'b1;
                win_ch  = k;
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sel_vld_d = sel_vld_q;
        ivec_d    = ivec_q;
        guard_d   = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
`ifdef VIC_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (istb) begin
                    state_d   = SEL;
                    sel_vld_d = win_vld;
                    sel_d     = win_vld ? IDX_W'(win_ch) : '0;
                    ivec_d    = win_vld ? (irq_vec[16*win_ch +: 16] & 16'hFFFC) : VEC_NONE;
                end
            end
            SEL:  state_d = ACK;
            ACK: begin
                state_d = HOLD;
`ifdef VIC_ROUND_ROBIN_EN
                if (sel_vld_q && !vm_init)
                    rr_d = (sel_q == IDX_W'(NUM_IRQ - 1)) ? '0 : sel_q + 1'b1;
`endif
            end
            HOLD: begin
                if (!istb) begin
                    state_d = IDLE;
                    guard_d = 2'd2;
                end
            end
            default: state_d = IDLE;
        endcase
        if (vm_init) begin
            state_d   = IDLE;
            sel_d     = '0;
            sel_vld_d = 1'b0;
            ivec_d    = '0;
            guard_d   = 2'd0;
        end
        // Computed from next-state values so the registered virq never lags a state change.
        virq_d = !vm_init && (state_d == IDLE) && (guard_d == 2'd0) && (|irq_req);
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            sel_vld_q <= 1'b0;
            ivec_q    <= '0;
            guard_q   <= 2'd0;
            virq_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            sel_vld_q <= sel_vld_d;
            ivec_q    <= ivec_d;
            guard_q   <= guard_d;
            virq_q    <= virq_d;
        end
    end

`ifdef VIC_ROUND_ROBIN_EN
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`endif

    always_comb begin
        irq_ack = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            irq_ack[i] = (state_q == ACK) && sel_vld_q && (sel_q == IDX_W'(i));
    end

    assign iack = (state_q == ACK);
    assign virq = virq_q;
    assign ivec = ivec_q;

endmodule

// File: tb/tb_vic_wb.sv
// Self-checking bench for vic_wb: vector table, hand-written corner sequences and randomized fetches vs. a model.
module tb_vic_wb;

    localparam int N = 8;

    logic              clk_p = 1'b0;
    logic              rst_n;
    logic              vm_init;
    logic [N-1:0]      irq_req;
    logic [16*N-1:0]   irq_vec;
    logic [N-1:0]      irq_ack;
    logic              virq;
    logic              istb;
    logic [15:0]       ivec;
    logic              iack;

    int n_checks = 0;
    int n_errors = 0;
    int mrr      = 0;
    logic [15:0] vecs [N];

    typedef struct {
        logic [7:0]  req;
        logic        exp_virq;
        logic [15:0] exp_vec;
        logic [7:0]  exp_ack;
        int          drop;
    } vec_t;
    vec_t tbl [6];

    vic_wb #(.NUM_IRQ(N), .VEC_NONE(16'o000000)) dut (
        .clk_p(clk_p), .rst_n(rst_n), .vm_init(vm_init), .irq_req(irq_req),
        .irq_vec(irq_vec), .irq_ack(irq_ack), .virq(virq), .istb(istb),
        .ivec(ivec), .iack(iack)
    );

    always #5 clk_p = ~clk_p;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: first requesting channel in search order starting at 'start'.
    function automatic int winner(input logic [7:0] req, input int start);
        for (int k = 0; k < N; k++)
            if (req[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic int search_start();
`ifdef VIC_ROUND_ROBIN_EN
        return mrr;
`else
        return 0;
`endif
    endfunction

    task automatic reset_pulse();
        @(negedge clk_p);
        rst_n = 1'b0; istb = 1'b0; vm_init = 1'b0; irq_req = '0;
        @(negedge clk_p);
        rst_n = 1'b1;
        mrr = 0;
    endtask

    // One full vector fetch. drop: cycles after irq_ack when the device releases (>2 = never).
    task automatic fetch(input string nm, input logic [15:0] ev, input logic [7:0] ea, input int drop);
        int cnt;
        istb = 1'b1;
        @(negedge clk_p);
        chk({nm, "_setup_iack"}, iack, 1'b0);
        chk({nm, "_setup_ivec"}, ivec, ev);
        chk({nm, "_sel_virq"}, virq, 1'b0);
        cnt = 1;
        while (iack !== 1'b1 && cnt < 8) begin
            @(negedge clk_p);
            cnt++;
        end
        chk({nm, "_latency"}, cnt, 2);
        chk({nm, "_ivec"}, ivec, ev);
        chk({nm, "_irq_ack"}, irq_ack, ea);
        if (drop == 0) irq_req = irq_req & ~ea;
        @(negedge clk_p);
        chk({nm, "_iack_pulse"}, iack, 1'b0);
        chk({nm, "_irq_ack_pulse"}, irq_ack, 8'h00);
        chk({nm, "_hold_ivec"}, ivec, ev);
        if (drop == 1) irq_req = irq_req & ~ea;
        istb = 1'b0;
        @(negedge clk_p);
        chk({nm, "_guard1_virq"}, virq, 1'b0);
        if (drop == 2) irq_req = irq_req & ~ea;
        @(negedge clk_p);
        chk({nm, "_guard2_virq"}, virq, 1'b0);
        chk({nm, "_guard_iack"}, iack, 1'b0);
        @(negedge clk_p);
        chk({nm, "_post_virq"}, virq, |irq_req);
        chk({nm, "_post_iack"}, iack, 1'b0);
        chk({nm, "_idle_ivec"}, ivec, ev);
    endtask

    initial begin
        int w;
        logic [7:0] rq, ea;
        logic [15:0] ev;

        tbl[0] = '{req: 8'h04, exp_virq: 1'b1, exp_vec: 16'o000060, exp_ack: 8'h04, drop: 0};
        tbl[1] = '{req: 8'h01, exp_virq: 1'b1, exp_vec: 16'o000100, exp_ack: 8'h01, drop: 1};
        tbl[2] = '{req: 8'h80, exp_virq: 1'b1, exp_vec: 16'o177774, exp_ack: 8'h80, drop: 2};
        tbl[3] = '{req: 8'h20, exp_virq: 1'b1, exp_vec: 16'o000310, exp_ack: 8'h20, drop: 0};
        tbl[4] = '{req: 8'h00, exp_virq: 1'b0, exp_vec: 16'o000000, exp_ack: 8'h00, drop: 0};
        tbl[5] = '{req: 8'h40, exp_virq: 1'b1, exp_vec: 16'o000314, exp_ack: 8'h40, drop: 1};

        vecs[0] = 16'o000100; vecs[1] = 16'o000064; vecs[2] = 16'o000060; vecs[3] = 16'o000070;
        vecs[4] = 16'o000300; vecs[5] = 16'o000310; vecs[6] = 16'o000314; vecs[7] = 16'o177777;
        for (int i = 0; i < N; i++) irq_vec[16*i +: 16] = vecs[i];

        rst_n = 1'b0; vm_init = 1'b0; istb = 1'b0; irq_req = '0;
        #1;
        chk("rst_virq", virq, 1'b0);
        chk("rst_iack", iack, 1'b0);
        chk("rst_ivec", ivec, 16'h0);
        chk("rst_irq_ack", irq_ack, 8'h00);
        @(negedge clk_p);
        @(negedge clk_p);
        rst_n = 1'b1;

        // Table of single-channel fetches
        for (int t = 0; t < 6; t++) begin
            irq_req = tbl[t].req;
            @(negedge clk_p);
            chk($sformatf("tbl%0d_virq", t), virq, tbl[t].exp_virq);
            fetch($sformatf("tbl%0d", t), tbl[t].exp_vec, tbl[t].exp_ack, tbl[t].drop);
        end

        // Two requests: ch1 first, then ch4 once ch1 releases
        reset_pulse();
        irq_req = 8'h12;
        @(negedge clk_p);
        chk("prio_virq", virq, 1'b1);
        fetch("prio_ch1", 16'o000064, 8'h02, 0);
        fetch("prio_ch4", 16'o000300, 8'h10, 0);

        // Request withdrawn between virq and istb
        irq_req = 8'h08;
        @(negedge clk_p);
        chk("drop_virq", virq, 1'b1);
        irq_req = 8'h00;
        fetch("drop_none", 16'o000000, 8'h00, 0);

        // istb released during SEL still completes
        irq_req = 8'h08;
        @(negedge clk_p);
        istb = 1'b1;
        @(negedge clk_p);
        istb = 1'b0;
        @(negedge clk_p);
        chk("early_iack", iack, 1'b1);
        chk("early_irq_ack", irq_ack, 8'h08);
        chk("early_ivec", ivec, 16'o000070);
        irq_req = 8'h00;
        @(negedge clk_p);
        chk("early_iack_off", iack, 1'b0);
        repeat (3) @(negedge clk_p);

        // vm_init in HOLD
        irq_req = 8'h04;
        @(negedge clk_p);
        istb = 1'b1;
        @(negedge clk_p);
        @(negedge clk_p);
        chk("init_hold_iack_on", iack, 1'b1);
        @(negedge clk_p);
        vm_init = 1'b1;
        @(negedge clk_p);
        chk("init_hold_iack", iack, 1'b0);
        chk("init_hold_virq", virq, 1'b0);
        chk("init_hold_ivec", ivec, 16'h0);
        chk("init_hold_irq_ack", irq_ack, 8'h00);
        vm_init = 1'b0; istb = 1'b0;
        @(negedge clk_p);
        chk("init_guard_clear", virq, 1'b1);

        // vm_init together with istb: no acknowledge
        istb = 1'b1; vm_init = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_p);
            chk($sformatf("init_istb_iack%0d", c), iack, 1'b0);
            chk($sformatf("init_istb_virq%0d", c), virq, 1'b0);
        end
        istb = 1'b0; vm_init = 1'b0;
        @(negedge clk_p);
        chk("init_istb_virq_back", virq, 1'b1);

        // Asynchronous reset during SEL
        istb = 1'b1;
        @(negedge clk_p);
        chk("async_sel_ivec", ivec, 16'o000060);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ivec", ivec, 16'h0);
        chk("async_virq", virq, 1'b0);
        chk("async_iack", iack, 1'b0);
        chk("async_irq_ack", irq_ack, 8'h00);
        istb = 1'b0; irq_req = '0;
        @(negedge clk_p);
        rst_n = 1'b1;
        mrr = 0;

        // Persistent ch0+ch1 requests
        irq_req = 8'h03;
        @(negedge clk_p);
        chk("rr_virq", virq, 1'b1);
        fetch("rr_g0", 16'o000100, 8'h01, 3);
`ifdef VIC_ROUND_ROBIN_EN
        fetch("rr_g1", 16'o000064, 8'h02, 3);
`else
        fetch("rr_g1", 16'o000100, 8'h01, 3);
`endif
        fetch("rr_g2", 16'o000100, 8'h01, 3);

        // Randomized fetches against the reference model
        reset_pulse();
        for (int r = 0; r < 30; r++) begin
            rq = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rq = 8'h00;
            irq_req = rq;
            @(negedge clk_p);
            chk($sformatf("rnd%0d_virq", r), virq, |rq);
            w  = winner(rq, search_start());
            ev = (w < 0) ? 16'o000000 : (vecs[w] & 16'hFFFC);
            ea = (w < 0) ? 8'h00 : 8'(1 << w);
            fetch($sformatf("rnd%0d", r), ev, ea, int'($urandom_range(0, 2)));
            if (w >= 0) mrr = (w + 1) % N;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
